// File: rtl/dcache_nway.sv
// dcache_nway: set-associative, write-back, write-allocate data cache with one
// system-bus master port. A miss stalls the core, writes back a dirty victim if
// needed, fetches the line beat by beat, installs it, then replays as a hit.
// Optional build macro: DCACHE_PERF_CNT_EN adds saturating hit_count/miss_count.
module dcache_nway #(
    parameter int WAYS           = 2,
    parameter int SETS           = 512,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      mem_active,
    input  logic                      load,
    input  logic [1:0]                size,
    input  logic [63:0]               in_addr,
    input  logic [63:0]               in_data,
    output logic [63:0]               memwb_loadeddata,
    output logic                      load_str_done,
    output logic                      MEMEX_stall
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int LINE_W = LINE_BEATS * BUS_DATA_WIDTH;
    localparam int OFF_W  = $clog2(LINE_BEATS * 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // System bus command encoding: direction in bits [11:8], target in [15:12].
    localparam int SYSBUS_READ   = 1;
    localparam int SYSBUS_WRITE  = 0;
    localparam int SYSBUS_MEMORY = 1;
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_RD = BUS_TAG_WIDTH'((SYSBUS_READ << 8) | (SYSBUS_MEMORY << 12));
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR = BUS_TAG_WIDTH'((SYSBUS_WRITE << 8) | (SYSBUS_MEMORY << 12));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_WAIT, S_FILL_DATA, S_INSTALL
    } state_t;

    // Zero-extended item of the requested size from a right-aligned doubleword.
    function automatic logic [63:0] f_item(input logic [63:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    return {56'd0, d[7:0]};
            2'd1:    return {48'd0, d[15:0]};
            2'd2:    return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    // Byte-enable mask for a store of the given size at the given byte offset.
    function automatic logic [7:0] f_bmask(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return 8'(m << off);
    endfunction

    logic [LINE_W-1:0]         r_data  [WAYS][SETS];
    logic [TAG_W-1:0]          r_tag   [WAYS][SETS];
    logic [SETS-1:0]           r_valid [WAYS];
    logic [SETS-1:0]           r_dirty [WAYS];
    logic [PTR_W-1:0]          r_rr    [SETS];
    logic [LINE_W-1:0]         r_fill;

    state_t                    r_state;
    logic [BEAT_W-1:0]         r_cnt;
    logic [PTR_W-1:0]          r_victim;
    logic [IDX_W-1:0]          r_idx;
    logic [TAG_W-1:0]          r_ltag;
    logic                      r_bus_reqcyc;
    logic                      r_bus_respack;
    logic [BUS_DATA_WIDTH-1:0] r_bus_req;
    logic [BUS_TAG_WIDTH-1:0]  r_bus_reqtag;
    logic                      r_done;

    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [OFF_W-4:0]          w_word;
    logic [2:0]                w_bsel;
    logic [WAYS-1:0]           w_hitvec;
    logic [PTR_W-1:0]          w_hitway;
    logic [PTR_W-1:0]          w_victim;
    logic                      w_vfound;
    logic                      w_hit;
    logic                      w_miss;
    logic [63:0]               w_word_data;
    logic [63:0]               w_wdata;
    logic [7:0]                w_bmask;
    logic [63:0]               w_merged;
    logic [LINE_W-1:0]         w_vline;
    logic [BEAT_W-1:0]         w_next_cnt;
    logic                      w_unused;

    assign w_idx      = in_addr[OFF_W +: IDX_W];
    assign w_tag      = in_addr[63 -: TAG_W];
    assign w_word     = in_addr[OFF_W-1:3];
    assign w_bsel     = in_addr[2:0];
    assign w_unused   = ^bus_resptag;
    assign w_next_cnt = r_cnt + 1'b1;
    assign w_vline    = r_data[r_victim][r_idx];

    // Tag compare across ways and victim selection (first invalid, else round-robin).
    always_comb begin
        w_hitvec = '0;
        w_hitway = '0;
        w_victim = r_rr[w_idx];
        w_vfound = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            w_hitvec[i] = r_valid[i][w_idx] && (r_tag[i][w_idx] == w_tag);
            if (w_hitvec[i]) w_hitway = PTR_W'(i);
            if (!w_vfound && !r_valid[i][w_idx]) begin
                w_victim = PTR_W'(i);
                w_vfound = 1'b1;
            end
        end
    end

    assign w_hit       = mem_active && (r_state == S_IDLE) && (|w_hitvec);
    assign w_miss      = mem_active && (r_state == S_IDLE) && !(|w_hitvec);
    assign w_word_data = r_data[w_hitway][w_idx][64*w_word +: 64];
    assign w_wdata     = in_data << {w_bsel, 3'b000};
    assign w_bmask     = f_bmask(size, w_bsel);

    // Byte-merge of the store data into the addressed doubleword.
    always_comb begin
        w_merged = w_word_data;
        for (int b = 0; b < 8; b++) begin
            if (w_bmask[b]) w_merged[8*b +: 8] = w_wdata[8*b +: 8];
        end
    end

    assign memwb_loadeddata = (w_hit && load) ? f_item(w_word_data >> {w_bsel, 3'b000}, size) : 64'd0;
    assign MEMEX_stall      = mem_active && !w_hit;
    assign load_str_done    = r_done;
    assign bus_reqcyc       = r_bus_reqcyc;
    assign bus_respack      = r_bus_respack;
    assign bus_req          = r_bus_req;
    assign bus_reqtag       = r_bus_reqtag;

    // Line data, tags and fill buffer; gated by FSM state so no reset is needed.
    always_ff @(posedge clk) begin
        if (r_state == S_INSTALL) begin
            r_data[r_victim][r_idx] <= r_fill;
            r_tag[r_victim][r_idx]  <= r_ltag;
        end else if (w_hit && !load) begin
            r_data[w_hitway][w_idx][64*w_word +: 64] <= w_merged;
        end
        if ((r_state == S_FILL_WAIT || r_state == S_FILL_DATA) && bus_respcyc)
            r_fill[BUS_DATA_WIDTH*r_cnt +: BUS_DATA_WIDTH] <= bus_resp;
    end

    // Valid/dirty bits and per-set round-robin pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WAYS; i++) begin
                r_valid[i] <= '0;
                r_dirty[i] <= '0;
            end
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else if (r_state == S_INSTALL) begin
            r_valid[r_victim][r_idx] <= 1'b1;
            r_dirty[r_victim][r_idx] <= 1'b0;
            r_rr[r_idx] <= (r_rr[r_idx] == PTR_W'(WAYS - 1)) ? '0 : r_rr[r_idx] + 1'b1;
        end else if (w_hit && !load) begin
            r_dirty[w_hitway][w_idx] <= 1'b1;
        end
    end

    // Miss FSM with registered bus outputs and the access-done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_victim      <= '0;
            r_idx         <= '0;
            r_ltag        <= '0;
            r_bus_reqcyc  <= 1'b0;
            r_bus_respack <= 1'b0;
            r_bus_req     <= '0;
            r_bus_reqtag  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_hit;
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_idx        <= w_idx;
                        r_ltag       <= w_tag;
                        r_victim     <= w_victim;
                        r_bus_reqcyc <= 1'b1;
                        if (r_dirty[w_victim][w_idx]) begin
                            r_state      <= S_WB_REQ;
                            r_bus_req    <= BUS_DATA_WIDTH'({r_tag[w_victim][w_idx], w_idx, {OFF_W{1'b0}}});
                            r_bus_reqtag <= TAG_WR;
                        end else begin
                            r_state      <= S_FILL_REQ;
                            r_bus_req    <= BUS_DATA_WIDTH'({w_tag, w_idx, {OFF_W{1'b0}}});
                            r_bus_reqtag <= TAG_RD;
                        end
                    end
                end
                S_WB_REQ: begin
                    if (bus_reqack) begin
                        r_state   <= S_WB_DATA;
                        r_cnt     <= '0;
                        r_bus_req <= w_vline[0 +: BUS_DATA_WIDTH];
                    end
                end
                S_WB_DATA: begin
                    if (r_cnt == LAST_BEAT) begin
                        r_state      <= S_FILL_REQ;
                        r_bus_reqcyc <= 1'b0;
                        r_bus_req    <= '0;
                        r_bus_reqtag <= '0;
                    end else begin
                        r_cnt     <= w_next_cnt;
                        r_bus_req <= w_vline[BUS_DATA_WIDTH*w_next_cnt +: BUS_DATA_WIDTH];
                    end
                end
                S_FILL_REQ: begin
                    if (!r_bus_reqcyc) begin
                        r_bus_reqcyc <= 1'b1;
                        r_bus_req    <= BUS_DATA_WIDTH'({r_ltag, r_idx, {OFF_W{1'b0}}});
                        r_bus_reqtag <= TAG_RD;
                    end else if (bus_reqack) begin
                        r_state       <= S_FILL_WAIT;
                        r_bus_reqcyc  <= 1'b0;
                        r_bus_req     <= '0;
                        r_bus_reqtag  <= '0;
                        r_bus_respack <= 1'b1;
                        r_cnt         <= '0;
                    end
                end
                S_FILL_WAIT, S_FILL_DATA: begin
                    if (bus_respcyc) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_state       <= S_INSTALL;
                            r_bus_respack <= 1'b0;
                        end else begin
                            r_state <= S_FILL_DATA;
                            r_cnt   <= w_next_cnt;
                        end
                    end
                end
                S_INSTALL: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Saturating hit/miss counters; a miss is counted once, at line install.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
            if ((r_state == S_INSTALL) && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Directed testbench for dcache_nway: fills, hits, byte stores, dirty
// write-back of the round-robin victim, delayed request ack, reset mid-fill.
`timescale 1ns/1ps
module tb_dcache_nway;

    localparam logic [12:0] TAG_RD = 13'h1100;
    localparam logic [12:0] TAG_WR = 13'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc, bus_respack, bus_respcyc, bus_reqack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;
    logic        mem_active, load;
    logic [1:0]  size;
    logic [63:0] in_addr, in_data, memwb_loadeddata;
    logic        load_str_done, MEMEX_stall;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_nway dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .mem_active(mem_active), .load(load), .size(size),
        .in_addr(in_addr), .in_data(in_data),
        .memwb_loadeddata(memwb_loadeddata),
        .load_str_done(load_str_done), .MEMEX_stall(MEMEX_stall)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic start_access(input logic ld, input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd);
        mem_active = 1'b1;
        load       = ld;
        size       = sz;
        in_addr    = addr;
        in_data    = wd;
    endtask

    // Called at a falling edge with the access presented and expected to hit now.
    task automatic finish_hit(input string tag, input logic [63:0] exp);
        #1;
        check({tag, "_stall"}, MEMEX_stall, 1'b0);
        check({tag, "_data"}, memwb_loadeddata, exp);
        @(negedge clk);
        check({tag, "_done"}, load_str_done, 1'b1);
        mem_active = 1'b0;
        load       = 1'b0;
    endtask

    task automatic hit_access(input string tag, input logic ld, input logic [1:0] sz,
                              input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] exp);
        start_access(ld, sz, addr, wd);
        finish_hit(tag, exp);
    endtask

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (!bus_reqcyc && i < 40) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_reqcyc"}, bus_reqcyc, 1'b1);
    endtask

    task automatic req_phase(input string tag, input logic [63:0] addr, input logic [12:0] rtag, input int delay);
        wait_req(tag);
        check({tag, "_addr"}, bus_req, addr);
        check({tag, "_tag"}, bus_reqtag, rtag);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d_addr", tag, d), bus_req, addr);
            check($sformatf("%s_hold%0d_tag", tag, d), bus_reqtag, rtag);
            check($sformatf("%s_hold%0d_stall", tag, d), MEMEX_stall, 1'b1);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
    endtask

    task automatic fill_beats(input string tag, input logic [63:0] base, input int n);
        check({tag, "_respack"}, bus_respack, 1'b1);
        for (int k = 0; k < n; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(k) + 64'd1;
            @(negedge clk);
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic service_fill(input string tag, input logic [63:0] addr, input logic [63:0] base, input int delay);
        req_phase(tag, addr, TAG_RD, delay);
        fill_beats(tag, base, 8);
        check({tag, "_install_stall"}, MEMEX_stall, 1'b1);
        @(negedge clk);
    endtask

    task automatic wb_phase(input string tag, input logic [63:0] addr, input logic [63:0] base,
                            input int ov_k, input logic [63:0] ov_v);
        int cnt;
        logic [63:0] exp;
        req_phase(tag, addr, TAG_WR, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus_reqcyc) break;
            exp = (cnt == ov_k) ? ov_v : base + 64'(cnt) + 64'd1;
            check($sformatf("%s_beat%0d", tag, cnt), bus_req, exp);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_nbeats"}, 64'(cnt), 64'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mem_active = 1'b0; load = 1'b0; size = 2'd0;
        in_addr = '0; in_data = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        bus_resp = '0; bus_resptag = '0;
        repeat (2) @(negedge clk);

        // Outputs during reset
        mem_active = 1'b1;
        #1;
        check("rst_reqcyc", bus_reqcyc, 1'b0);
        check("rst_respack", bus_respack, 1'b0);
        check("rst_req", bus_req, 64'd0);
        check("rst_reqtag", bus_reqtag, 13'd0);
        check("rst_done", load_str_done, 1'b0);
        check("rst_loaded", memwb_loadeddata, 64'd0);
        check("rst_stall_act", MEMEX_stall, 1'b1);
        mem_active = 1'b0;
        #1;
        check("rst_stall_idle", MEMEX_stall, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Cold load miss at 0x1000, beats k+1
        start_access(1'b1, 2'd3, 64'h1000, 64'd0);
        #1;
        check("ld1000_miss_stall", MEMEX_stall, 1'b1);
        service_fill("f1000", 64'h1000, 64'h0, 0);
        finish_hit("ld1000", 64'h1);
        @(negedge clk);
        check("ld1000_done_pulse", load_str_done, 1'b0);

        // Byte store and sized loads on the filled line
        hit_access("st1003", 1'b0, 2'd0, 64'h1003, 64'hAB, 64'd0);
        hit_access("ld1000_d", 1'b1, 2'd3, 64'h1000, 64'd0, 64'h0000_0000_AB00_0001);
        hit_access("ld1002_h", 1'b1, 2'd1, 64'h1002, 64'd0, 64'hAB00);
        hit_access("ld1003_b", 1'b1, 2'd0, 64'h1003, 64'd0, 64'hAB);
        hit_access("ld1008_b", 1'b1, 2'd0, 64'h1008, 64'd0, 64'h2);
        hit_access("ld1010_w", 1'b1, 2'd2, 64'h1010, 64'd0, 64'h3);

        // Request ack held off five cycles
        start_access(1'b1, 2'd3, 64'h2000, 64'd0);
        #1;
        check("ld2000_miss_stall", MEMEX_stall, 1'b1);
        service_fill("f2000", 64'h2000, 64'h100, 5);
        finish_hit("ld2000", 64'h101);
        hit_access("ld2038", 1'b1, 2'd3, 64'h2038, 64'd0, 64'h108);

        // Three dirty lines aliasing set 0: third miss evicts line A
        start_access(1'b1, 2'd3, 64'h10000, 64'd0);
        service_fill("fA", 64'h10000, 64'h200, 0);
        finish_hit("ldA", 64'h201);
        hit_access("stA", 1'b0, 2'd3, 64'h10008, 64'h1111_2222_3333_4444, 64'd0);
        start_access(1'b1, 2'd3, 64'h18000, 64'd0);
        service_fill("fB", 64'h18000, 64'h300, 0);
        finish_hit("ldB", 64'h301);
        hit_access("stB", 1'b0, 2'd2, 64'h18010, 64'hCAFE_F00D, 64'd0);
        start_access(1'b1, 2'd3, 64'h20000, 64'd0);
        #1;
        check("ldC_miss_stall", MEMEX_stall, 1'b1);
        wb_phase("wbA", 64'h10000, 64'h200, 1, 64'h1111_2222_3333_4444);
        service_fill("fC", 64'h20000, 64'h400, 0);
        finish_hit("ldC", 64'h401);
        hit_access("ldB_kept", 1'b1, 2'd3, 64'h18010, 64'd0, 64'hCAFE_F00D);

        // Reset during fill beat 3, then the same address misses again
        start_access(1'b1, 2'd3, 64'h3000, 64'd0);
        req_phase("f3000", 64'h3000, TAG_RD, 0);
        fill_beats("f3000", 64'h600, 3);
        bus_respcyc = 1'b1;
        bus_resp    = 64'h604;
        reset       = 1'b0;
        #1;
        check("mid_rst_reqcyc", bus_reqcyc, 1'b0);
        check("mid_rst_respack", bus_respack, 1'b0);
        check("mid_rst_req", bus_req, 64'd0);
        check("mid_rst_reqtag", bus_reqtag, 13'd0);
        check("mid_rst_done", load_str_done, 1'b0);
        check("mid_rst_loaded", memwb_loadeddata, 64'd0);
        check("mid_rst_stall", MEMEX_stall, 1'b1);
        @(negedge clk);
        bus_respcyc = 1'b0;
        reset       = 1'b1;
        #1;
        check("reload_miss_stall", MEMEX_stall, 1'b1);
        service_fill("f3000b", 64'h3000, 64'h500, 0);
        finish_hit("ld3000", 64'h501);

        // One miss then four hits from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_access(1'b1, 2'd3, 64'h4000, 64'd0);
        service_fill("f4000", 64'h4000, 64'h700, 0);
        finish_hit("ld4000", 64'h701);
        for (int i = 0; i < 4; i++)
            hit_access($sformatf("ld4000_h%0d", i), 1'b1, 2'd3, 64'h4000 + 64'(8*i), 64'd0, 64'h701 + 64'(i));
`ifdef DCACHE_PERF_CNT_EN
        check("perf_miss_count", 64'(miss_count), 64'd1);
        check("perf_hit_count", 64'(hit_count), 64'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, giving associativity; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter SETS, default 512, giving the set count; it is a power of two, at least 2.
REQ-003 SHALL have parameter BUS_DATA_WIDTH, default 64, giving bus beat width in bits.
REQ-004 SHALL have parameter BUS_TAG_WIDTH, default 13, giving bus tag width in bits.
REQ-005 SHALL have parameter LINE_BEATS, default 8, giving beats per line; a line is LINE_BEATS*BUS_DATA_WIDTH bits.
REQ-006 SHALL have one clock; reset is asynchronous and active-low; ports clk and reset.
REQ-007 SHALL have port clk, input, 1 bit: the clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have bus ports bus_reqcyc (out, 1), bus_respack (out, 1), bus_req (out, BUS_DATA_WIDTH), bus_reqtag (out, BUS_TAG_WIDTH), bus_respcyc (in, 1), bus_reqack (in, 1), bus_resp (in, BUS_DATA_WIDTH) and bus_resptag (in, BUS_TAG_WIDTH).
REQ-010 SHALL have core ports mem_active (in, 1), load (in, 1; 1 = load), size (in, 2; 0 = byte, 1 = half, 2 = word, 3 = double), in_addr (in, 64) and in_data (in, 64).
REQ-011 SHALL have outputs memwb_loadeddata (out, 64), load_str_done (out, 1) and MEMEX_stall (out, 1).

Function
REQ-012 SHALL split the address as offset = log2(LINE_BEATS*8) bits, index = log2(SETS) bits and tag = the remaining upper bits; each way holds valid, dirty, tag and data per set.
REQ-013 SHALL declare a hit when mem_active is high, the FSM is IDLE and any valid way's tag matches; a hit holds MEMEX_stall low in the same cycle.
REQ-014 SHALL, on a load hit, drive memwb_loadeddata combinationally with the addressed size-aligned item, zero-extended; load_str_done is a registered one-cycle pulse on the next edge.
REQ-015 SHALL, on a store hit, merge only the bytes selected by size and in_addr[2:0] at the clock edge, set dirty, and pulse load_str_done the next cycle.
REQ-016 SHALL hold MEMEX_stall high combinationally when mem_active is high and the access misses or the FSM is not IDLE.
REQ-017 SHALL choose the victim as the first invalid way, else the way named by a per-set round-robin pointer; the pointer advances on every fill of that set.
REQ-018 SHALL run the FSM IDLE -> (victim dirty ? WB_REQ -> WB_DATA :) FILL_REQ -> FILL_WAIT -> FILL_DATA -> INSTALL -> IDLE.
REQ-019 SHALL, in WB_REQ, drive bus_reqcyc=1, bus_req={victim tag, index, 0} and bus_reqtag=SYSBUS_WRITE<<8|SYSBUS_MEMORY<<12, holding them until bus_reqack.
REQ-020 SHALL, in WB_DATA, drive LINE_BEATS consecutive beats with bus_reqcyc=1, lowest beat first, then deassert bus_reqcyc.
REQ-021 SHALL, in FILL_REQ, drive bus_reqcyc=1, bus_req = line-aligned in_addr and bus_reqtag=SYSBUS_READ<<8|SYSBUS_MEMORY<<12, holding them until bus_reqack.
REQ-022 SHALL hold bus_respack high in FILL_WAIT and FILL_DATA; each bus_respcyc beat is stored at the next beat slot starting at beat 0, wrapping is forbidden, and a beat counter reaching LINE_BEATS-1 moves the FSM to INSTALL.
REQ-023 SHALL, in INSTALL, write the line with valid=1, dirty=0 and the new tag; the stalled access then completes as a hit the following cycle.
REQ-024 SHALL ignore bus_respcyc outside FILL_WAIT and FILL_DATA.
REQ-025 SHALL ignore mem_active changes while a miss is in flight; the access is resampled in IDLE.

Reset
REQ-026 SHALL, while reset is low, clear every valid and dirty bit and every round-robin pointer, and force the FSM to IDLE.
REQ-027 SHALL, while reset is low, drive bus_reqcyc, bus_respack, bus_req, bus_reqtag, load_str_done and memwb_loadeddata to 0; MEMEX_stall then follows mem_active.
REQ-028 SHALL abandon any bus transaction cut off by reset mid-operation; no partial line is installed.

Configuration
REQ-029 SHALL, with DCACHE_PERF_CNT_EN defined, add 32-bit output ports hit_count and miss_count, reset to 0, that count hits and misses, saturate at all-ones and count a miss once per fill.
REQ-030 SHALL, with DCACHE_PERF_CNT_EN undefined, omit both ports and both counters.

Verification
REQ-031 SHALL cover: reset, then a load from 0x1000 with memory beat k = k+1 -> one read request, 8 beats, stall released, memwb_loadeddata = 1.
REQ-032 SHALL cover: a store of size=0 with data 0xAB at 0x1003 after a fill, then a load of size=3 at 0x1000 -> 0x0000_0000_AB00_0001 (byte 3 replaced, other bytes of the beat-0 value 0x1 kept), with dirty set.
REQ-033 SHALL cover: WAYS=2 with three dirty-line addresses aliasing index 0 -> the third miss writes back the round-robin victim (WB address matches its tag, 8 beats) before the fill.
REQ-034 SHALL cover: bus_reqack delayed 5 cycles -> bus_req and bus_reqtag stay stable and MEMEX_stall stays high throughout.
REQ-035 SHALL cover: reset asserted at fill beat 3 -> FSM IDLE, bus outputs 0, and a reload of the same address misses again.
REQ-036 SHALL cover: DCACHE_PERF_CNT_EN defined, 1 miss then 4 hits -> miss_count=1, hit_count=5.
